red_pitaya_pll_ctrl: RTL and testbench

Supervisor for the board PLL: measures the external clock candidate and selects the PLL input (`clk_select`: 1 = internal CLKIN1, 0 = external CLKIN2). Drives the PLL reset and qualifies lock, with retry and fallback to the internal source. Sits directly upstream of the PLL, driving its `clk_select` and `rstn` inputs. Runs from a free-running clock independent of the PLL outputs, e.g. a PS fabric clock.

---
 rtl/red_pitaya_pll_ctrl.sv | 174 +++++++++++++++++
 tb/tb_red_pitaya_pll_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_pll_ctrl.sv
// PLL input supervisor: measures the external clock, picks the PLL source, drives PLL reset and qualifies lock.
// Optional macro PLL_CTRL_RUN_MONITOR_EN keeps measuring the external clock while running on it.
module red_pitaya_pll_ctrl #(
  parameter int WIN_LEN      = 1024,
  parameter int EDGE_MIN     = 900,
  parameter int EDGE_MAX     = 1100,
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_ext_en,
  input  logic        ext_tgl,
  input  logic        pll_locked,
  output logic        clk_select,
  output logic        pll_rstn,
  output logic        sts_locked,
  output logic        sts_ext,
  output logic [2:0]  sts_state,
  output logic [15:0] sts_edge_cnt,
  output logic [15:0] sts_relock_cnt
);

  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [WW-1:0] WIN_M1  = WW'(WIN_LEN - 1);
  localparam logic [RW-1:0] RST_M1  = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STAB_M1 = SW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [15:0]   E_MIN   = 16'(EDGE_MIN);
  localparam logic [15:0]   E_MAX   = 16'(EDGE_MAX);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    MEAS  = 3'd1,
    PRST  = 3'd2,
    LOCKW = 3'd3,
    RUN   = 3'd4
  } state_t;

  state_t          state;
  logic            tgl_m, tgl_s, tgl_d, lock_m, lock_s, lock_lo_q, cfg_q;
  logic            use_ext, ext_ok;
  logic [WW-1:0]   win_cnt;
  logic [15:0]     edge_cnt, edge_nxt, relock_nxt;
  logic [RW-1:0]   rst_cnt;
  logic [SW-1:0]   stab_cnt;
  logic [TW-1:0]   to_cnt;
  logic            edge_det, win_run, win_end, win_ok, lock_lost, cfg_chg;

  // Synchronizers are left unreset so they settle while rst is held.
  always_ff @(posedge clk) begin
    tgl_m     <= ext_tgl;
    tgl_s     <= tgl_m;
    tgl_d     <= tgl_s;
    lock_m    <= pll_locked;
    lock_s    <= lock_m;
    lock_lo_q <= !lock_s;
    cfg_q     <= cfg_ext_en;
  end

  assign edge_det = tgl_s ^ tgl_d;
`ifdef PLL_CTRL_RUN_MONITOR_EN
  assign win_run  = (state == MEAS) || ((state == RUN) && use_ext);
`else
  assign win_run  = (state == MEAS);
`endif
  assign win_end    = win_run && (win_cnt == WIN_M1);
  assign edge_nxt   = (edge_cnt == 16'hFFFF) ? edge_cnt : edge_cnt + {15'd0, edge_det};
  assign win_ok     = (edge_nxt >= E_MIN) && (edge_nxt <= E_MAX);
  assign relock_nxt = (sts_relock_cnt == 16'hFFFF) ? sts_relock_cnt : sts_relock_cnt + 16'd1;
  assign lock_lost  = !lock_s && lock_lo_q;
  assign cfg_chg    = (ext_ok && (cfg_ext_en != use_ext)) || (use_ext && cfg_q && !cfg_ext_en);

  // Derived from the registered select, so it never disagrees with it.
  assign sts_ext   = ~clk_select;
  assign sts_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= INIT;
      clk_select     <= 1'b1;
      pll_rstn       <= 1'b0;
      sts_locked     <= 1'b0;
      sts_edge_cnt   <= '0;
      sts_relock_cnt <= '0;
      use_ext        <= 1'b0;
      ext_ok         <= 1'b0;
      win_cnt        <= '0;
      edge_cnt       <= '0;
      rst_cnt        <= '0;
      stab_cnt       <= '0;
      to_cnt         <= '0;
    end else begin
      if (win_run && !win_end) begin
        win_cnt  <= win_cnt + 1'b1;
        edge_cnt <= edge_nxt;
      end else begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end
      if (win_end) begin
        sts_edge_cnt <= edge_nxt;
        ext_ok       <= win_ok;
      end

      case (state)
        INIT: state <= MEAS;
        MEAS: if (win_end) begin
          use_ext    <= cfg_ext_en & win_ok;
          clk_select <= !(cfg_ext_en & win_ok);
          pll_rstn   <= 1'b0;
          rst_cnt    <= '0;
          state      <= PRST;
        end
        PRST: if (rst_cnt == RST_M1) begin
          pll_rstn <= 1'b1;
          stab_cnt <= '0;
          to_cnt   <= '0;
          state    <= LOCKW;
        end else begin
          rst_cnt <= rst_cnt + 1'b1;
        end
        LOCKW: begin
          to_cnt   <= to_cnt + 1'b1;
          stab_cnt <= lock_s ? stab_cnt + 1'b1 : '0;
          if (lock_s && (stab_cnt == STAB_M1)) begin
            sts_locked <= 1'b1;
            state      <= RUN;
          end else if (to_cnt == TO_M1) begin
            // Timeout on either source retries on the internal one.
            sts_relock_cnt <= relock_nxt;
            use_ext        <= 1'b0;
            clk_select     <= 1'b1;
            pll_rstn       <= 1'b0;
            rst_cnt        <= '0;
            state          <= PRST;
          end
        end
        RUN: if (lock_lost) begin
          sts_relock_cnt <= relock_nxt;
          sts_locked     <= 1'b0;
          win_cnt        <= '0;
          edge_cnt       <= '0;
          state          <= MEAS;
        end else if (cfg_chg) begin
          sts_locked <= 1'b0;
          win_cnt    <= '0;
          edge_cnt   <= '0;
          state      <= MEAS;
        end
`ifdef PLL_CTRL_RUN_MONITOR_EN
        else if (win_end && !win_ok) begin
          sts_relock_cnt <= relock_nxt;
          sts_locked     <= 1'b0;
          use_ext        <= 1'b0;
          clk_select     <= 1'b1;
          pll_rstn       <= 1'b0;
          rst_cnt        <= '0;
          state          <= PRST;
        end
`endif
        default: begin
          sts_locked <= 1'b0;
          state      <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_pll_ctrl.sv
// Randomized bench for red_pitaya_pll_ctrl against a scenario-level model of source choice, timing and retry counts.
module tb_red_pitaya_pll_ctrl;
  localparam int WIN = 100, EMIN = 90, EMAX = 110, RSTC = 4, STAB = 8, TO = 50;

  logic        clk = 1'b0, rst = 1'b1, cfg_ext_en = 1'b0, ext_tgl = 1'b0, pll_locked = 1'b1;
  logic        clk_select, pll_rstn, sts_locked, sts_ext;
  logic [2:0]  sts_state;
  logic [15:0] sts_edge_cnt, sts_relock_cnt;

  int n_chk = 0, n_err = 0;
  int tgl_per = 0;
  bit exp_ext;

  always #5 clk = ~clk;

  red_pitaya_pll_ctrl #(
    .WIN_LEN(WIN), .EDGE_MIN(EMIN), .EDGE_MAX(EMAX),
    .RST_CYCLES(RSTC), .LOCK_STABLE(STAB), .LOCK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .cfg_ext_en(cfg_ext_en), .ext_tgl(ext_tgl), .pll_locked(pll_locked),
    .clk_select(clk_select), .pll_rstn(pll_rstn), .sts_locked(sts_locked), .sts_ext(sts_ext),
    .sts_state(sts_state), .sts_edge_cnt(sts_edge_cnt), .sts_relock_cnt(sts_relock_cnt)
  );

  // External clock stand-in: one toggle every tgl_per cycles, static when 0.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (tgl_per != 0) begin
        if (ph >= tgl_per - 1) begin ext_tgl = ~ext_tgl; ph = 0; end
        else ph++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"},    clk_select, 1);
    chk({tag, "_rstn"},   pll_rstn, 0);
    chk({tag, "_lock"},   sts_locked, 0);
    chk({tag, "_ext"},    sts_ext, 0);
    chk({tag, "_state"},  sts_state, 0);
    chk({tag, "_edges"},  sts_edge_cnt, 0);
    chk({tag, "_relock"}, sts_relock_cnt, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    chk_reset("rst");
    rst = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int bound, output int n);
    n = 0;
    do begin tick(); n++; end while (sts_state !== s && n < bound);
    if (sts_state !== s) chk({tag, "_to"}, 32'(sts_state), 32'(s));
  endtask

  // Reset, then bring-up: source chosen by cfg and measured rate, lock after INIT+window+reset+stable.
  task automatic bring_up(input int per, input bit cfg);
    int n, viol;
    logic prev;
    tgl_per    = per;
    cfg_ext_en = cfg;
    pll_locked = 1'b1;
    exp_ext    = cfg && (per == 1);
    do_reset();
    n = 0; viol = 0; prev = clk_select;
    do begin
      tick(); n++;
      if (clk_select !== prev && pll_rstn !== 1'b0) viol++;
      prev = clk_select;
    end while (!sts_locked && n < 400);
    chk("bring_t",    n, 1 + WIN + RSTC + STAB);
    chk("sel_glitch", viol, 0);
    chk("edge_cnt",   sts_edge_cnt, (per == 0) ? 0 : WIN / per);
    chk("clk_sel",    clk_select, !exp_ext);
    chk("sts_ext",    sts_ext, exp_ext);
    chk("rstn_up",    pll_rstn, 1);
    chk("run_state",  sts_state, 4);
    chk("relock0",    sts_relock_cnt, 0);
  endtask

  initial begin
    int pers[6];
    int n, lat, low, per, act, seen;
    bit cfg, remeas;
    pers = '{0, 1, 2, 4, 5, 1};

    // valid external clock, then absent external clock
    bring_up(1, 1'b1);
    bring_up(0, 1'b1);

    for (int it = 0; it < 8; it++) begin
      per = pers[$urandom_range(0, 5)];
      cfg = 1'($urandom_range(0, 1));
      bring_up(per, cfg);
      act = $urandom_range(0, 2);
      if (act == 0) begin
        pll_locked = 1'b0; tick(); pll_locked = 1'b1;
        repeat (10) tick();
        chk("glitch_lock",   sts_locked, 1);
        chk("glitch_relock", sts_relock_cnt, 0);
      end else if (act == 1) begin
        pll_locked = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (sts_locked && lat < 20);
        pll_locked = 1'b1;
        chk("loss_lat",    (lat >= 3 && lat <= 4), 1);
        chk("loss_state",  sts_state, 1);
        chk("loss_relock", sts_relock_cnt, 1);
        wait_state("relock", 3'd4, 400, n);
        chk("relock_sel",  clk_select, !exp_ext);
        chk("relock_cnt",  sts_relock_cnt, 1);
      end else begin
        remeas     = (per == 1);
        cfg_ext_en = !cfg;
        repeat (2) tick();
        chk("cfg_state", sts_state, remeas ? 1 : 4);
        if (remeas) begin
          exp_ext = !cfg;
          wait_state("cfg_relock", 3'd4, 400, n);
        end
        chk("cfg_sel",    clk_select, !exp_ext);
        chk("cfg_relock", sts_relock_cnt, 0);
      end
    end

    // lock timeout on external source, retry on internal
    tgl_per = 1; cfg_ext_en = 1'b1; pll_locked = 1'b0;
    do_reset();
    wait_state("lockw", 3'd3, 300, n);
    chk("to_sel_ext", clk_select, 0);
    n = 0;
    do begin tick(); n++; end while (sts_relock_cnt == 0 && n < 200);
    chk("to_t",       n, TO);
    chk("to_relock",  sts_relock_cnt, 1);
    chk("to_sel_int", clk_select, 1);
    chk("to_rstn",    pll_rstn, 0);
    low = 1; n = 0;
    do begin
      tick(); n++;
      if (sts_relock_cnt == 1 && !pll_rstn) low++;
    end while (sts_relock_cnt < 2 && n < 200);
    chk("rstn_w",    low, RSTC);
    chk("retry_t",   n, TO + RSTC);
    chk("retry_sel", clk_select, 1);

    // reset asserted inside lock wait
    wait_state("lockw2", 3'd3, 100, n);
    rst = 1'b1;
    tick();
    chk_reset("mid_rst");
    rst = 1'b0;

    // external rate collapses while running on it
    bring_up(1, 1'b1);
    tgl_per = 2;
    seen = 0;
    repeat (300) begin
      tick();
      if (!pll_rstn) seen = 1;
    end
    chk("mon_state", sts_state, 4);
`ifdef PLL_CTRL_RUN_MONITOR_EN
    chk("mon_sel",    clk_select, 1);
    chk("mon_relock", sts_relock_cnt, 1);
    chk("mon_rstn",   seen, 1);
`else
    chk("mon_sel",    clk_select, 0);
    chk("mon_relock", sts_relock_cnt, 0);
    chk("mon_rstn",   seen, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
